// File: rtl/vector_unpack_queue.sv
// rtl/vector_unpack_queue.sv - replays a packed LENGTH x IN_W vector as a serial OUT_W word stream
// Lanes go out highest first, so a shift-register queue downstream rebuilds the same vector.
module vector_unpack_queue #(
    parameter int LENGTH   = 16,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 16,
    parameter int SIGN_EXT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_en,
    input  logic [LENGTH*IN_W-1:0]     in_vector,
    output logic                       in_ready,
    input  logic                       out_block,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(LENGTH)-1:0]  out_idx,
    output logic                       out_last,
    output logic                       drop_err
);
    localparam int IDX_W = $clog2(LENGTH);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [LENGTH*IN_W-1:0]   r_hold;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_drop;
    logic                     w_load;
    logic                     w_advance;
    logic                     w_clear;
    logic                     w_last;
    logic [IDX_W-1:0]         w_lane_sel;
    logic [IN_W-1:0]          w_lane;
    logic [OUT_W-1:0]         w_ext;

    assign w_last     = (r_state == S_SEND) && (r_idx == IDX_W'(LENGTH - 1));
    assign w_lane_sel = IDX_W'(LENGTH - 1) - r_idx;

    always_comb begin
        w_lane = '0;
        for (int k = 0; k < LENGTH; k++) begin
            if (w_lane_sel == IDX_W'(k)) begin
                w_lane = r_hold[k*IN_W +: IN_W];
            end
        end
    end

    assign w_ext = (SIGN_EXT != 0) ? {{(OUT_W-IN_W){w_lane[IN_W-1]}}, w_lane}
                                   : {{(OUT_W-IN_W){1'b0}}, w_lane};

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_en) begin
                    w_load       = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (!out_block) begin
                    if (w_last) begin
                        // A vector offered on the final transfer is chained with no bubble.
                        if (in_en) begin
                            w_load = 1'b1;
                        end else begin
                            w_clear      = 1'b1;
                            w_next_state = S_IDLE;
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_idx   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_hold <= in_vector;
                r_idx  <= '0;
            end else if (w_advance) begin
                r_idx <= r_idx + 1'b1;
            end else if (w_clear) begin
                r_idx <= '0;
            end
            if (in_en && !in_ready) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE) || (w_last && !out_block);
    assign out_valid = (r_state == S_SEND);
    assign out_data  = (r_state == S_SEND) ? w_ext : '0;
    assign out_idx   = r_idx;
    assign out_last  = w_last;
    assign drop_err  = r_drop;
endmodule

// File: tb/tb_vector_unpack_queue.sv
// tb/tb_vector_unpack_queue.sv - directed self-checking bench for vector_unpack_queue
module tb_vector_unpack_queue;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_en;
    logic [127:0] in_vector;
    logic         out_block;

    logic         o0_ready, o0_valid, o0_last, o0_drop;
    logic [15:0]  o0_data;
    logic [3:0]   o0_idx;
    logic         o1_ready, o1_valid, o1_last, o1_drop;
    logic [15:0]  o1_data;
    logic [3:0]   o1_idx;

    int total = 0;
    int bad   = 0;

    logic [127:0] q_vec;
    int           q_cnt;

    always #5 clk = ~clk;

    vector_unpack_queue #(.LENGTH(16), .IN_W(8), .OUT_W(16), .SIGN_EXT(0)) u0 (
        .clk(clk), .reset(reset), .in_en(in_en), .in_vector(in_vector), .in_ready(o0_ready),
        .out_block(out_block), .out_valid(o0_valid), .out_data(o0_data), .out_idx(o0_idx),
        .out_last(o0_last), .drop_err(o0_drop)
    );

    vector_unpack_queue #(.LENGTH(16), .IN_W(8), .OUT_W(16), .SIGN_EXT(1)) u1 (
        .clk(clk), .reset(reset), .in_en(in_en), .in_vector(in_vector), .in_ready(o1_ready),
        .out_block(out_block), .out_valid(o1_valid), .out_data(o1_data), .out_idx(o1_idx),
        .out_last(o1_last), .drop_err(o1_drop)
    );

    // 16-deep shift-register queue: newest element enters lane 0.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_vec <= '0;
            q_cnt <= 0;
        end else if (o0_valid && !out_block) begin
            q_vec <= {q_vec[119:0], o0_data[7:0]};
            q_cnt <= q_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] lane(input logic [127:0] v, input int k);
        return v[k*8 +: 8];
    endfunction

    // Offers v, then follows it word by word until its last word is on the bus
    // (not yet transferred). Optional 3-cycle stall and one illegal offer.
    task automatic run_vec(input logic [127:0] v, input int stall_cyc, input int drop_cyc,
                           output int last_cyc);
        int exp_idx;
        exp_idx  = 0;
        last_cyc = 0;
        chk("offer_ready", {31'b0, o0_ready}, 32'd1);
        in_vector = v;
        in_en     = 1'b1;
        step();
        in_en = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            chk("valid", {31'b0, o0_valid}, 32'd1);
            chk("idx", {28'b0, o0_idx}, exp_idx);
            chk("data", {16'b0, o0_data}, {24'b0, lane(v, 15 - exp_idx)});
            chk("last", {31'b0, o0_last}, (exp_idx == 15) ? 32'd1 : 32'd0);
            if (cyc == drop_cyc + 1) chk("drop_set", {31'b0, o0_drop}, 32'd1);
            out_block = (cyc >= stall_cyc) && (cyc < stall_cyc + 3);
            if (cyc == drop_cyc) begin
                chk("busy_ready", {31'b0, o0_ready}, 32'd0);
                in_vector = ~v;
                in_en     = 1'b1;
            end else begin
                in_en = 1'b0;
            end
            if (o0_last && !out_block) begin
                last_cyc = cyc;
                break;
            end
            if (!out_block) exp_idx++;
            step();
        end
        out_block = 1'b0;
        in_en     = 1'b0;
        if (last_cyc == 0) chk("last_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] vb;
        int lc;

        reset = 1'b1; in_en = 1'b0; in_vector = '0; out_block = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'b0, o0_valid}, 32'd0);
        chk("rst_data", {16'b0, o0_data}, 32'd0);
        chk("rst_idx", {28'b0, o0_idx}, 32'd0);
        chk("rst_last", {31'b0, o0_last}, 32'd0);
        chk("rst_drop", {31'b0, o0_drop}, 32'd0);
        chk("rst_ready", {31'b0, o0_ready}, 32'd1);

        // Ramp vector: lanes 0..15 = 0x00..0x0F, out_data 0x000F down to 0x0000.
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'(k);
        run_vec(v, -100, -100, lc);
        chk("ramp_len", lc, 32'd16);
        step();
        chk("ramp_idle_valid", {31'b0, o0_valid}, 32'd0);
        chk("ramp_idle_data", {16'b0, o0_data}, 32'd0);
        chk("ramp_idle_ready", {31'b0, o0_ready}, 32'd1);

        // Extension: lane 15 = 0x80, lane 14 = 0x7F.
        v = '0;
        v[127:120] = 8'h80;
        v[119:112] = 8'h7F;
        in_vector = v; in_en = 1'b1;
        step();
        in_en = 1'b0;
        chk("zext_w0", {16'b0, o0_data}, 32'h0080);
        chk("sext_w0", {16'b0, o1_data}, 32'hFF80);
        step();
        chk("zext_w1", {16'b0, o0_data}, 32'h007F);
        chk("sext_w1", {16'b0, o1_data}, 32'h007F);
        for (int i = 0; i < 20 && o0_valid; i++) step();
        chk("ext_drained", {31'b0, o0_valid}, 32'd0);

        // Stall for 3 cycles at idx=5: 19 cycles to the last word.
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'(k * 13 + 7);
        run_vec(v, 6, -100, lc);
        chk("stall_len", lc, 32'd19);
        step();
        chk("stall_idle", {31'b0, o0_valid}, 32'd0);

        // Back-to-back: B offered on A's last word goes out with no gap.
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'(8'hA0 + k);
        for (int k = 0; k < 16; k++) vb[k*8 +: 8] = 8'(8'h50 + k * 3);
        run_vec(v, -100, -100, lc);
        run_vec(vb, -100, -100, lc);
        chk("b2b_len", lc, 32'd16);
        chk("b2b_nodrop", {31'b0, o0_drop}, 32'd0);
        step();
        chk("b2b_idle", {31'b0, o0_valid}, 32'd0);

        // Illegal offer at idx=3 is dropped and flagged.
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'(8'hF0 - k * 5);
        run_vec(v, -100, 4, lc);
        chk("drop_len", lc, 32'd16);
        step();
        chk("drop_sticky", {31'b0, o0_drop}, 32'd1);
        chk("drop_idle", {31'b0, o0_valid}, 32'd0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("drop_cleared", {31'b0, o0_drop}, 32'd0);

        // Round trip through a shift-register queue, with a stall in the middle.
        v = {$urandom, $urandom, $urandom, $urandom};
        run_vec(v, 9, -100, lc);
        step();
        chk("rt_count", q_cnt, 32'd16);
        for (int k = 0; k < 16; k++) chk("rt_lane", {24'b0, lane(q_vec, k)}, {24'b0, lane(v, k)});

        // Reset mid-vector at idx=8.
        in_vector = v; in_en = 1'b1;
        step();
        in_en = 1'b0;
        repeat (8) step();
        chk("mid_idx", {28'b0, o0_idx}, 32'd8);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, o0_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, o0_ready}, 32'd1);
        chk("mid_rst_idx", {28'b0, o0_idx}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("mid_rst_quiet", {31'b0, o0_valid}, 32'd0);
        chk("mid_rst_data", {16'b0, o0_data}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
